// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch/decode types, widths and opcode/func constants
package mips_pkg;
  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;
  localparam int JTGT_W  = 26;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, KILL} fetch_state_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_SLT     = 6'h2A;
endpackage

// File: rtl/fetch_ifid_reg.sv
// rtl/fetch_ifid_reg.sv - IF/ID output register with a one-entry skid buffer
module fetch_ifid_reg
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [ADDR_W-1:0]  load_pc4,
  input  logic               stall,
  input  logic               flush,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc4
);
  logic               skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc4;
  logic               free;

  assign free = !valid || !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid      <= 1'b0;
      instr      <= '0;
      pc4        <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc4   <= '0;
    end else if (flush) begin
      valid      <= 1'b0;
      skid_valid <= 1'b0;
    end else if (free) begin
      // the skid word is older than anything arriving now, so it drains first
      if (skid_valid) begin
        valid      <= 1'b1;
        instr      <= skid_instr;
        pc4        <= skid_pc4;
        skid_valid <= 1'b0;
      end else if (load) begin
        valid <= 1'b1;
        instr <= load_instr;
        pc4   <= load_pc4;
      end else begin
        valid <= 1'b0;
      end
    end else if (load) begin
      skid_valid <= 1'b1;
      skid_instr <= load_instr;
      skid_pc4   <= load_pc4;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, fetch FSM and imem handshake feeding the IF/ID register
// Defining FETCH_PERF_EN adds the perf_fetched/perf_stall counters.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall_in,
  input  logic               jal,
  input  logic [JTGT_W-1:0]  jal_target,
  output logic               valid_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_plus4_out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);
  localparam logic [ADDR_W-1:0] START_PC = {RESET_PC[ADDR_W-1:2], 2'b00};

  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, tgt, tgt_n, target, pc_inc;
  logic              beat, redirect, load;

  assign imem_req  = (state == FETCH) || (state == KILL);
  assign imem_addr = pc;
  assign beat      = imem_req && imem_ready;
  assign redirect  = jal && valid_out && !stall_in;
  assign target    = {pc_plus4_out[ADDR_W-1:ADDR_W-4], jal_target, 2'b00};
  assign pc_inc    = pc + ADDR_W'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= START_PC;
      tgt   <= START_PC;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      tgt   <= tgt_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    tgt_n   = tgt;
    load    = 1'b0;
    case (state)
      IDLE: state_n = FETCH;
      FETCH: begin
        if (redirect) begin
          // an unanswered request must complete at its old address before retargeting
          if (beat) begin
            pc_n = target;
          end else begin
            tgt_n   = target;
            state_n = KILL;
          end
        end else if (beat) begin
          load = 1'b1;
          pc_n = pc_inc;
          if (valid_out && stall_in) state_n = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_n    = target;
          state_n = FETCH;
        end else if (!stall_in) begin
          state_n = FETCH;
        end
      end
      KILL: begin
        if (beat) begin
          pc_n    = tgt;
          state_n = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  fetch_ifid_reg u_ifid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_instr (imem_rdata),
    .load_pc4   (pc_inc),
    .stall      (stall_in),
    .flush      (redirect),
    .valid      (valid_out),
    .instr      (instr_out),
    .pc4        (pc_plus4_out)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (beat) perf_fetched <= perf_fetched + 32'd1;
      if (valid_out && stall_in) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - vector table, directed sequences and scoreboard for fetch_stage
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ready, stall_in, jal, valid_out;
  logic [31:0] imem_addr, imem_rdata, instr_out, pc_plus4_out;
  logic [25:0] jal_target;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc4;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall, w_perf_fetched, w_perf_stall;
`endif
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall_in(stall_in),
    .jal(jal), .jal_target(jal_target), .valid_out(valid_out),
    .instr_out(instr_out), .pc_plus4_out(pc_plus4_out)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(1'b1), .imem_rdata(w_addr), .stall_in(1'b0),
    .jal(1'b0), .jal_target(26'd0), .valid_out(w_valid),
    .instr_out(w_instr), .pc_plus4_out(w_pc4)
`ifdef FETCH_PERF_EN
    , .perf_fetched(w_perf_fetched), .perf_stall(w_perf_stall)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } sb_t;
  sb_t         sb[$];
  sb_t         e;
  logic [31:0] exp_pc, prev_addr;
  logic        kill_pend, prev_wait, redir;

  // request/response monitor: evaluated mid-cycle for the coming rising edge
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      exp_pc    = 32'h0;
      kill_pend = 1'b0;
      prev_wait = 1'b0;
      prev_addr = 32'h0;
    end else begin
      redir = jal && valid_out && !stall_in;
      if (imem_req) begin
        chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
        if (prev_wait) chk("addr_stable", imem_addr, prev_addr);
        if (kill_pend) begin
          if (imem_ready) kill_pend = 1'b0;
        end else begin
          chk("req_addr", imem_addr, exp_pc);
          if (imem_ready && !redir) begin
            e.instr = imem_addr ^ 32'hA5A5_0000;
            e.pc4   = imem_addr + 32'd4;
            sb.push_back(e);
            exp_pc = exp_pc + 32'd4;
          end else if (!imem_ready && redir) begin
            kill_pend = 1'b1;
          end
        end
      end
      prev_wait = imem_req && !imem_ready;
      prev_addr = imem_addr;
      if (valid_out && !stall_in) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_pc4", pc_plus4_out, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("sb_instr", instr_out, e.instr);
          chk("sb_pc4", pc_plus4_out, e.pc4);
        end
      end
      if (redir) begin
        sb.delete();
        exp_pc = {pc_plus4_out[31:28], jal_target, 2'b00};
      end
    end
  end

  task automatic step(input int r, input int s, input int j, input logic [25:0] t,
                      input int e_req, input logic [31:0] e_addr, input int e_vld,
                      input logic [31:0] e_pc4, input string tag);
    imem_ready = r[0];
    stall_in   = s[0];
    jal        = j[0];
    jal_target = t;
    @(negedge clk);
    chk({tag, "_req"}, {31'd0, imem_req}, e_req);
    chk({tag, "_addr"}, imem_addr, e_addr);
    chk({tag, "_valid"}, {31'd0, valid_out}, e_vld);
    if (e_vld != 0) begin
      chk({tag, "_pc4"}, pc_plus4_out, e_pc4);
      chk({tag, "_instr"}, instr_out, (e_pc4 - 32'd4) ^ 32'hA5A5_0000);
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic        rdy;
    logic        stl;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc4;
  } vec_t;
  vec_t tbl [20];

  initial begin
    tbl[0]  = {1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
    tbl[1]  = {1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[2]  = {1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[3]  = {1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[4]  = {1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[5]  = {1'b1, 1'b0, 1'b1, 32'h04, 1'b1, 32'h04};
    tbl[6]  = {1'b1, 1'b0, 1'b1, 32'h08, 1'b1, 32'h08};
    tbl[7]  = {1'b1, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h0C};
    tbl[8]  = {1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h10};
    tbl[9]  = {1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h00};
    tbl[10] = {1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h00};
    tbl[11] = {1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h14};
    tbl[12] = {1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h14};
    tbl[13] = {1'b1, 1'b1, 1'b0, 32'h18, 1'b1, 32'h14};
    tbl[14] = {1'b1, 1'b1, 1'b0, 32'h18, 1'b1, 32'h14};
    tbl[15] = {1'b1, 1'b1, 1'b0, 32'h18, 1'b1, 32'h14};
    tbl[16] = {1'b0, 1'b0, 1'b0, 32'h18, 1'b1, 32'h14};
    tbl[17] = {1'b1, 1'b0, 1'b1, 32'h18, 1'b1, 32'h18};
    tbl[18] = {1'b0, 1'b0, 1'b1, 32'h1C, 1'b1, 32'h1C};
    tbl[19] = {1'b0, 1'b0, 1'b1, 32'h1C, 1'b0, 32'h00};

    rst_n = 1'b0; imem_ready = 1'b0; stall_in = 1'b0; jal = 1'b0; jal_target = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req", {31'd0, imem_req}, 32'd0);
    chk("reset_addr", imem_addr, 32'h0);
    chk("reset_valid", {31'd0, valid_out}, 32'd0);
    chk("reset_instr", instr_out, 32'h0);
    chk("reset_pc4", pc_plus4_out, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step(int'(tbl[i].rdy), int'(tbl[i].stl), 0, 26'd0, int'(tbl[i].req), tbl[i].addr,
           int'(tbl[i].vld), tbl[i].pc4, $sformatf("row%0d", i));
      if (i == 1) begin
        chk("wrap_addr_a", w_addr, 32'hFFFF_FFFC);
        chk("wrap_pc4_a", w_pc4, 32'hFFFF_FFFC);
        chk("wrap_valid", {31'd0, w_valid}, 32'd1);
      end
      if (i == 2) begin
        chk("wrap_addr_b", w_addr, 32'h0000_0000);
        chk("wrap_pc4_b", w_pc4, 32'h0000_0000);
        chk("wrap_instr", w_instr, 32'hFFFF_FFFC);
      end
    end

    step(1, 0, 0, 26'd0,        1, 32'h0000_001C, 0, 32'h0,          "pre_jal");
    step(0, 0, 1, 26'h3FF_FFFF, 1, 32'h0000_0020, 1, 32'h0000_0020, "jal_far");
    step(1, 0, 0, 26'd0,        1, 32'h0000_0020, 0, 32'h0,          "kill_hold_a");
    step(1, 0, 0, 26'd0,        1, 32'h0FFF_FFFC, 0, 32'h0,          "tgt_far");
    step(1, 0, 0, 26'd0,        1, 32'h1000_0000, 1, 32'h1000_0000, "region_cross");
    step(1, 0, 0, 26'd0,        1, 32'h1000_0004, 1, 32'h1000_0004, "seq_a");
    step(1, 0, 0, 26'd0,        1, 32'h1000_0008, 1, 32'h1000_0008, "seq_b");
    step(1, 0, 0, 26'd0,        1, 32'h1000_000C, 1, 32'h1000_000C, "seq_c");
    step(0, 0, 1, 26'h000_0040, 1, 32'h1000_0010, 1, 32'h1000_0010, "jal_kill");
    step(1, 0, 0, 26'd0,        1, 32'h1000_0010, 0, 32'h0,          "kill_hold_b");
    step(1, 0, 0, 26'd0,        1, 32'h1000_0100, 0, 32'h0,          "tgt_0100");
    step(1, 0, 0, 26'd0,        1, 32'h1000_0104, 1, 32'h1000_0104, "after_kill");
    step(1, 0, 1, 26'h000_0020, 1, 32'h1000_0108, 1, 32'h1000_0108, "jal_same_rdy");
    step(1, 0, 0, 26'd0,        1, 32'h1000_0080, 0, 32'h0,          "tgt_0080");
    step(1, 0, 0, 26'd0,        1, 32'h1000_0084, 1, 32'h1000_0084, "after_drop");
    step(1, 1, 1, 26'h000_0010, 1, 32'h1000_0088, 1, 32'h1000_0088, "jal_stalled");
    step(0, 1, 1, 26'h000_0010, 0, 32'h1000_008C, 1, 32'h1000_0088, "hold_jal_ign");
    step(0, 0, 1, 26'h000_0010, 0, 32'h1000_008C, 1, 32'h1000_0088, "jal_from_hold");
    step(1, 1, 0, 26'd0,        1, 32'h1000_0040, 0, 32'h0,          "stall_no_valid");

    imem_ready = 1'b0; stall_in = 1'b1; jal = 1'b0;
    @(negedge clk);
    chk("pre_arst_req", {31'd0, imem_req}, 32'd1);
    chk("pre_arst_valid", {31'd0, valid_out}, 32'd1);
    chk("pre_arst_pc4", pc_plus4_out, 32'h1000_0044);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_valid", {31'd0, valid_out}, 32'd0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_pc4", pc_plus4_out, 32'h0);
    stall_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(1, 0, 0, 26'd0, 0, 32'h0, 0, 32'h0, "rst_idle");
    step(1, 0, 0, 26'd0, 1, 32'h0, 0, 32'h0, "rst_fetch");
    step(0, 0, 0, 26'd0, 1, 32'h4, 1, 32'h4, "rst_first");
    step(0, 0, 0, 26'd0, 1, 32'h4, 0, 32'h0, "rst_drain");
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
